// File: rtl/prio_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module   : prio_arbiter8
//  Purpose  : 8-way arbiter with selectable fixed-priority / round-robin
//             policy, non-preemptive grants and a bounded hold time.
//  Revision : 1.0  initial release
// ============================================================================
module prio_arbiter8 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    input  logic       mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    // Last hold count value at which a grant is still allowed to run.
    localparam logic [7:0] c_hold_last = 8'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_id;
    logic       r_gnt_valid;
    logic       r_timeout;
    logic [2:0] r_ptr;
    logic [7:0] r_hold;

    logic [2:0] w_fixed_id;
    logic [2:0] w_rr_id;
    logic [2:0] w_winner;
    logic       w_req_any;
    logic       w_owner_req;
    logic       w_expired;
    logic       w_release;
    logic       w_timeout;

    // Fixed priority: the highest set request bit wins (later iterations override).
    always_comb begin
        w_fixed_id = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (req[k]) begin
                w_fixed_id = 3'(k);
            end
        end
    end

    // Round-robin: first set bit at or above the pointer, wrapping 7 -> 0.
    // Iterating downwards lets the closest candidate to the pointer win last.
    always_comb begin
        w_rr_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[r_ptr + 3'(i)]) begin
                w_rr_id = r_ptr + 3'(i);
            end
        end
    end

    // Policy select and grant-termination conditions.
    always_comb begin
        w_winner    = mode ? w_rr_id : w_fixed_id;
        w_req_any   = |req;
        w_owner_req = req[r_gnt_id];
        w_expired   = (r_hold == c_hold_last);
        w_release   = done | ~w_owner_req | w_expired;
        // An expiry only counts as a timeout when no normal release coincides.
        w_timeout   = w_expired & ~done & w_owner_req;
    end

    // Arbitration state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 8'd0;
            r_gnt_id    <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_ptr       <= 3'd0;
            r_hold      <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_req_any) begin
                        r_state     <= ST_GRANT;
                        r_gnt       <= 8'd1 << w_winner;
                        r_gnt_id    <= w_winner;
                        r_gnt_valid <= 1'b1;
                        r_hold      <= 8'd0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state     <= ST_RELEASE;
                        r_gnt       <= 8'd0;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= w_timeout;
                    end else begin
                        r_hold      <= r_hold + 8'd1;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    // Pointer moves past the last grantee in either policy.
                    r_ptr     <= r_gnt_id + 3'd1;
                    r_timeout <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= 8'd0;
                    r_gnt_valid <= 1'b0;
                    r_timeout   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_arbiter8
//  Purpose  : Self-checking bench for prio_arbiter8 (reference model plus
//             directed scenarios with literal expectations).
//  Revision : 1.0  initial release
// ============================================================================
module tb_prio_arbiter8;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    prio_arbiter8 #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner = -1 means nobody holds the resource; cool = a release cycle is pending.
    int         m_owner = -1;
    int         m_id    = 0;
    int         m_ptr   = 0;
    int         m_held  = 0;
    bit         m_cool  = 0;
    bit         m_to    = 0;

    function automatic int pick(input logic [7:0] r, input logic md, input int p);
        int w;
        w = -1;
        if (!md) begin
            for (int k = 0; k < 8; k++) if (r[k]) w = k;
        end else begin
            for (int i = 0; i < 8; i++) if (w < 0 && r[(p + i) % 8]) w = (p + i) % 8;
        end
        return w;
    endfunction

    // Model advance on each clock/reset event, then compare just after it.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_owner = -1; m_id = 0; m_ptr = 0; m_held = 0; m_cool = 0; m_to = 0;
            end else if (m_owner >= 0) begin
                m_held = m_held + 1;
                m_to   = 0;
                if (done || !req[m_owner] || m_held == HOLD) begin
                    m_to    = (m_held == HOLD) && !done && req[m_owner];
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = -1;
                    m_cool  = 1;
                end
            end else if (m_cool) begin
                m_cool = 0;
                m_to   = 0;
            end else begin
                m_to = 0;
                if (req != 8'd0) begin
                    m_owner = pick(req, mode, m_ptr);
                    m_id    = m_owner;
                    m_held  = 0;
                end
            end
            #1;
            chk("model_gnt",       gnt,       (m_owner >= 0) ? (32'd1 << m_id) : 32'd0);
            chk("model_gnt_id",    gnt_id,    m_id);
            chk("model_gnt_valid", gnt_valid, (m_owner >= 0) ? 1 : 0);
            chk("model_timeout",   timeout,   m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1; req = 8'd0; done = 1'b0; mode = 1'b0;
        tick(); tick();
        chk("reset_gnt",       gnt,       8'h00);
        chk("reset_gnt_id",    gnt_id,    3'd0);
        chk("reset_gnt_valid", gnt_valid, 1'b0);
        chk("reset_timeout",   timeout,   1'b0);
        rst = 1'b0;
        tick();
        chk("idle_no_req", gnt, 8'h00);

        // Fixed priority, done on 3rd grant cycle, then re-grant.
        mode = 1'b0; req = 8'h26;
        tick(); chk("fp_c1_gnt", gnt, 8'h20); chk("fp_c1_id", gnt_id, 3'd5);
        tick(); chk("fp_c2_gnt", gnt, 8'h20);
        tick(); chk("fp_c3_gnt", gnt, 8'h20); done = 1'b1;
        tick(); chk("fp_rel_gnt", gnt, 8'h00); chk("fp_rel_id", gnt_id, 3'd5);
        done = 1'b0;
        tick(); chk("fp_idle_gnt", gnt, 8'h00);
        tick(); chk("fp_regrant", gnt, 8'h20);
        req = 8'h00;
        tick(); tick(); tick();

        // Round-robin fairness from a fresh reset.
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b1; req = 8'hFF; done = 1'b1;
        for (int g = 0; g < 9; g++) begin
            int k;
            k = 0;
            while (!gnt_valid && k < 6) begin
                tick();
                k++;
            end
            chk("rr_order", gnt_id, g % 8);
            tick();
        end
        req = 8'h00; done = 1'b0;
        tick(); tick();

        // Hold expiry with a lone requester.
        mode = 1'b0; req = 8'h08;
        for (int c = 0; c < HOLD; c++) begin
            tick();
            chk("to_hold_gnt", gnt, 8'h08);
        end
        tick(); chk("to_pulse", timeout, 1'b1); chk("to_rel_gnt", gnt, 8'h00);
        mode = 1'b1; req = 8'h39;
        tick(); chk("to_pulse_end", timeout, 1'b0);
        tick(); chk("to_ptr_after", gnt_id, 3'd4);
        req = 8'h00;
        tick(); tick();

        // done coincides with expiry: normal release.
        mode = 1'b0; req = 8'h08;
        tick(); tick(); tick(); tick(); done = 1'b1;
        tick(); chk("col_timeout", timeout, 1'b0); chk("col_gnt", gnt, 8'h00);
        done = 1'b0; req = 8'h00;
        tick(); tick();

        // Requester withdrawal.
        mode = 1'b0; req = 8'h04;
        tick(); chk("wd_gnt2", gnt, 8'h04);
        req = 8'h40;
        tick(); chk("wd_rel", gnt, 8'h00);
        tick(); chk("wd_idle", gnt, 8'h00);
        tick(); chk("wd_gnt6", gnt_id, 3'd6);
        req = 8'h00;
        tick(); tick();

        // Asynchronous reset mid-grant.
        mode = 1'b0; req = 8'h08;
        tick(); chk("ar_gnt3", gnt, 8'h08);
        #2 rst = 1'b1;
        #1;
        chk("ar_gnt_drop",  gnt,       8'h00);
        chk("ar_valid",     gnt_valid, 1'b0);
        chk("ar_timeout",   timeout,   1'b0);
        mode = 1'b1; req = 8'h81;
        tick();
        rst = 1'b0;
        tick(); chk("ar_rr_ptr0", gnt, 8'h01); chk("ar_rr_id", gnt_id, 3'd0);
        req = 8'h00;
        tick(); tick();

        summary();
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_bad++;
        summary();
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prio_arbiter8.md
PRIO_ARBITER8 -- requirements
Module: prio_arbiter8

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, meaning the maximum number of cycles a grant is held without done (legal range 2..255).
REQ-002 clk  input  1  rising-edge clock; the single clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  8  request lines; bit k is requester k.
REQ-005 done  input  1  the current grantee releases the resource; sampled only in GRANT.
REQ-006 mode  input  1  arbitration policy: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 gnt  output  8  one-hot grant, registered.
REQ-008 gnt_id  output  3  binary index of the granted requester, registered.
REQ-009 gnt_valid  output  1  high while gnt is non-zero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by hold expiry.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and RELEASE.
REQ-012 In IDLE with req == 0, the block SHALL remain in IDLE with gnt = 0.
REQ-013 In IDLE with req != 0 at clock edge N, the block SHALL enter GRANT and present gnt, gnt_id and gnt_valid = 1 after edge N, giving one-cycle latency.
REQ-014 With mode = 0, the winner SHALL be the highest set bit of req; for example, req = 8'b0010_0110 grants index 5.
REQ-015 With mode = 1, the search SHALL start at pointer ptr and ascend with wrap 7 -> 0; the first set bit wins.
REQ-016 mode SHALL be sampled only at the arbitration edge; a change during GRANT SHALL NOT affect the current grant.
REQ-017 In GRANT, gnt and gnt_id SHALL remain stable and other requests SHALL be ignored; there is no pre-emption.
REQ-018 A hold counter SHALL clear on entry to GRANT and increment each cycle spent in GRANT.
REQ-019 GRANT SHALL exit to RELEASE on the first edge at which any of the following holds: done = 1; req[gnt_id] = 0; or the counter equals HOLD_MAX-1.
REQ-020 A hold-expiry exit SHALL assert timeout for exactly one cycle, concurrent with the RELEASE cycle.
REQ-021 If done = 1 or req[gnt_id] = 0 on the expiry edge, the exit SHALL be a normal release and timeout SHALL stay 0.
REQ-022 In RELEASE, gnt SHALL be 0, gnt_valid SHALL be 0, and gnt_id SHALL hold its last value.
REQ-023 In RELEASE, ptr SHALL be set to (gnt_id + 1) mod 8, so index 7 wraps to 0; the next state SHALL be IDLE.
REQ-024 ptr SHALL be updated in both modes, so that a later switch to round-robin starts after the last grantee.
REQ-025 The minimum time from one grant to the next SHALL be one grant cycle plus RELEASE plus IDLE, giving a two-cycle gap with gnt = 0.
REQ-026 done asserted outside GRANT SHALL be ignored.
REQ-027 gnt SHALL always equal 1 << gnt_id when gnt_valid = 1, and SHALL be 0 otherwise.

Reset
REQ-028 While rst = 1, the block SHALL hold state = IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, ptr = 0 and hold counter = 0, independent of clk.
REQ-029 Reset asserted mid-GRANT SHALL drop gnt immediately (asynchronously) and SHALL NOT produce a timeout pulse.
REQ-030 After rst deasserts, the first arbitration SHALL use ptr = 0.

Verification
REQ-031 Fixed priority: mode = 0, req = 8'h26, done pulsed on the 3rd GRANT cycle -> gnt = 8'h20, gnt_id = 5 for 3 cycles, then RELEASE with gnt = 0, then IDLE, then re-grant to 5.
REQ-032 Round-robin fairness: mode = 1, req = 8'hFF, done each grant cycle -> grant order 0,1,2,...,7,0 with wrap from 7 to 0.
REQ-033 Timeout: HOLD_MAX = 4, req = 8'h08 held, done = 0 -> gnt = 8'h08 for 4 cycles, then a single timeout pulse with gnt = 0; ptr = 4 afterwards.
REQ-034 Done/expiry collision: HOLD_MAX = 4, done = 1 on the 4th GRANT cycle -> release with timeout = 0.
REQ-035 Requester withdrawal: req[2] drops mid-grant -> RELEASE on the next edge; the request from req[6] is granted two cycles later.
REQ-036 Async reset: rst pulses between clock edges during a grant to 3 -> gnt = 0 immediately; after reset, with mode = 1 and req = 8'h81, grant goes to 0.
